// File: rtl/alu_exec16_if.sv
// Request/response bundle for the alu_exec16 execute stage: an accept handshake
// carrying opcode and operands, and a writeback handshake carrying result and flags.
interface alu_exec16_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  flags;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/alu_exec16.sv
// Sequential 16-bit ALU execute stage built around one shared ripple adder.
// Define ALU_MUL_EN to compile in the iterative shift-add multiplier (op 110).

module add16 (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);
    always_comb begin
        logic carry;
        sum_o = '0;
        carry = cin_i;
        for (int i = 0; i < 16; i++) begin
            sum_o[i] = x_i[i] ^ y_i[i] ^ carry;
            carry    = (x_i[i] & y_i[i]) | (carry & (x_i[i] ^ y_i[i]));
        end
        cout_o = carry;
    end
endmodule

module alu_exec16 #(
    parameter int MUL_STEPS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_exec16_if.slave  bus
);
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL1 = 3'b101;
`ifdef ALU_MUL_EN
    localparam logic [2:0] OP_MUL  = 3'b110;
`endif

    if (MUL_STEPS < 1 || MUL_STEPS > 16) begin : g_bad_mul_steps
        $error("alu_exec16: MUL_STEPS must lie in 1..16");
    end

    typedef enum logic [2:0] {S_IDLE, S_NEG, S_EXEC, S_MUL, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        b_sign_q;
    logic        c1_q;
    logic [15:0] result_q;
    logic [3:0]  flags_q;
    logic        accept;

    logic [15:0] add_x, add_y, add_sum;
    logic        add_cin, add_cout;

    logic [15:0] exec_res;
    logic        exec_c, exec_v;

`ifdef ALU_MUL_EN
    logic [3:0]  cnt_q;
    logic [15:0] mcand_q;
    logic [15:0] acc_q;
    logic        mcarry_q;
    logic        lost_q;
    logic        last_step;

    assign last_step = (cnt_q == 4'(MUL_STEPS - 1));
`endif

    assign accept = (state_q == S_IDLE) && bus.in_valid;

    add16 u_add16 (
        .x_i    (add_x),
        .y_i    (add_y),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    case (bus.op)
                        OP_SUB:  state_d = S_NEG;
`ifdef ALU_MUL_EN
                        OP_MUL:  state_d = S_MUL;
`endif
                        default: state_d = S_EXEC;
                    endcase
                end
            end
            S_NEG:  state_d = S_EXEC;
            S_EXEC: state_d = S_DONE;
`ifdef ALU_MUL_EN
            S_MUL:  if (last_step) state_d = S_EXEC;
`endif
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
    end

    assign bus.result = result_q;
    assign bus.flags  = flags_q;

    // The single adder is time-shared: negate in NEG, main pass in EXEC, accumulate in MUL.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        case (state_q)
            S_NEG: begin
                add_x   = ~b_q;
                add_cin = 1'b1;
            end
            S_EXEC: begin
                if (op_q == OP_ADD || op_q == OP_SUB) begin
                    add_x = a_q;
                    add_y = b_q;
                end else if (op_q == OP_SHL1) begin
                    add_x = a_q;
                    add_y = a_q;
                end
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
                add_x = acc_q;
                add_y = mcand_q;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        exec_res = a_q;
        exec_c   = 1'b0;
        exec_v   = 1'b0;
        case (op_q)
            OP_ADD: begin
                exec_res = add_sum;
                exec_c   = add_cout;
                exec_v   = (a_q[15] == b_q[15]) & (add_sum[15] != a_q[15]);
            end
            OP_SUB: begin
                exec_res = add_sum;
                exec_c   = c1_q | add_cout;
                exec_v   = (a_q[15] != b_sign_q) & (add_sum[15] != a_q[15]);
            end
            OP_AND:  exec_res = a_q & b_q;
            OP_OR:   exec_res = a_q | b_q;
            OP_XOR:  exec_res = a_q ^ b_q;
            OP_SHL1: begin
                exec_res = add_sum;
                exec_c   = add_cout;
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
                exec_res = acc_q;
                exec_c   = mcarry_q;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
        end else if (state_q == S_EXEC) begin
            result_q <= exec_res;
            flags_q  <= {exec_res[15], (exec_res == 16'h0000), exec_c, exec_v};
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded on accept before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q     <= bus.op;
            a_q      <= bus.a;
            b_q      <= bus.b;
            b_sign_q <= bus.b[15];
        end else if (state_q == S_NEG) begin
            b_q  <= add_sum;
            c1_q <= add_cout;
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (state_q == S_MUL) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    // lost_q remembers any multiplicand bit already shifted past bit 15.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_q    <= '0;
            mcand_q  <= bus.a;
            mcarry_q <= 1'b0;
            lost_q   <= 1'b0;
        end else if (state_q == S_MUL) begin
            if (b_q[cnt_q]) begin
                acc_q    <= add_sum;
                mcarry_q <= mcarry_q | add_cout | lost_q;
            end
            mcand_q <= {mcand_q[14:0], 1'b0};
            lost_q  <= lost_q | mcand_q[15];
        end
    end
`endif

endmodule
